bucket_scan_seq: RTL and testbench

//  Sequential, parametrised bucket lookup. Accepts one data word split into NUM_BUCKETS

---
 rtl/bucket_scan_seq.sv | 134 +++++++++++++
 tb/tb_bucket_scan_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bucket_scan_seq.sv
// Sequential bucket search: finds the first bucket above a threshold, scanning LANES
// buckets per cycle in MSB-first or LSB-first order, with valid/ready on both sides.
module bucket_scan_seq #(
    parameter int NUM_BUCKETS = 18,
    parameter int BUCKET_SZ   = 4,
    parameter int INPUT_WIDTH = NUM_BUCKETS * BUCKET_SZ,
    parameter int LANES       = 3,
    parameter int IDX_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_msb_first,
    input  logic [BUCKET_SZ-1:0]   in_thresh,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_found,
    output logic [NUM_BUCKETS-1:0] out_onehot,
    output logic [IDX_WIDTH-1:0]   out_index,
    output logic [BUCKET_SZ-1:0]   out_bucket
);

    localparam int NUM_GROUPS = NUM_BUCKETS / LANES;
    localparam int GROUP_W    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                   r_state;
    logic [GROUP_W-1:0]       r_group;
    logic [INPUT_WIDTH-1:0]   r_data;
    logic                     r_msbFirst;
    logic [BUCKET_SZ-1:0]     r_thresh;
    logic                     r_outValid;
    logic                     r_found;
    logic [NUM_BUCKETS-1:0]   r_onehot;
    logic [IDX_WIDTH-1:0]     r_index;
    logic [BUCKET_SZ-1:0]     r_bucket;

    logic                     w_hit;
    logic [IDX_WIDTH-1:0]     w_hitIdx;
    logic [BUCKET_SZ-1:0]     w_hitVal;

    assign in_ready   = (r_state == IDLE) && !reset;
    assign out_valid  = r_outValid;
    assign out_found  = r_found;
    assign out_onehot = r_onehot;
    assign out_index  = r_index;
    assign out_bucket = r_bucket;

    // Lanes are visited last-to-first so the earliest lane in search order overwrites any later hit.
    always_comb begin
        int                   idx;
        logic [BUCKET_SZ-1:0] val;
        w_hit    = 1'b0;
        w_hitIdx = '0;
        w_hitVal = '0;
        idx      = 0;
        val      = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (r_msbFirst)
                idx = NUM_BUCKETS - 1 - int'(r_group) * LANES - l;
            else
                idx = int'(r_group) * LANES + l;
            val = r_data[idx*BUCKET_SZ +: BUCKET_SZ];
            if (val > r_thresh) begin
                w_hit    = 1'b1;
                w_hitIdx = IDX_WIDTH'(idx);
                w_hitVal = val;
            end
        end
    end

    // Results land on the DONE transition; out_valid rises one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_group    <= '0;
            r_data     <= '0;
            r_msbFirst <= 1'b0;
            r_thresh   <= '0;
            r_outValid <= 1'b0;
            r_found    <= 1'b0;
            r_onehot   <= '0;
            r_index    <= '0;
            r_bucket   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data     <= in_data;
                        r_msbFirst <= in_msb_first;
                        r_thresh   <= in_thresh;
                        r_group    <= '0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_found  <= 1'b1;
                        r_index  <= w_hitIdx;
                        r_onehot <= NUM_BUCKETS'(1) << w_hitIdx;
                        r_bucket <= w_hitVal;
                        r_state  <= DONE;
                    end else if (r_group == LAST_GROUP) begin
                        r_found  <= 1'b0;
                        r_index  <= '0;
                        r_onehot <= '0;
                        r_bucket <= '0;
                        r_state  <= DONE;
                    end else begin
                        r_group <= r_group + GROUP_W'(1);
                    end
                end
                DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bucket_scan_seq.sv
// Directed scoreboard bench for bucket_scan_seq: a reference search model predicts each
// result and its latency; results are popped and compared when out_valid rises.
module tb_bucket_scan_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_data;
    logic        in_msb_first;
    logic [3:0]  in_thresh;
    logic        out_valid;
    logic        out_ready;
    logic        out_found;
    logic [17:0] out_onehot;
    logic [4:0]  out_index;
    logic [3:0]  out_bucket;

    typedef struct packed {
        logic        found;
        logic [4:0]  index;
        logic [17:0] onehot;
        logic [3:0]  bucket;
        logic [31:0] lat;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   cycle;
    int   acceptCycle;
    int   checkCount;
    int   failCount;

    bucket_scan_seq dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_msb_first(in_msb_first),
        .in_thresh   (in_thresh),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_found   (out_found),
        .out_onehot  (out_onehot),
        .out_index   (out_index),
        .out_bucket  (out_bucket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checkCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: walk all buckets in search order; group of the hit sets the latency.
    function automatic exp_t model(input logic [71:0] d, input logic msb, input logic [3:0] thr);
        exp_t e;
        logic [3:0] v;
        int k;
        e = '0;
        e.lat = 32'd7;
        for (int p = 0; p < 18; p++) begin
            k = msb ? 17 - p : p;
            v = d[k*4 +: 4];
            if (!e.found && v > thr) begin
                e.found  = 1'b1;
                e.index  = 5'(k);
                e.bucket = v;
                e.onehot = 18'(1) << k;
                e.lat    = 32'(p / 3 + 2);
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [71:0] d, input logic msb, input logic [3:0] thr);
        @(negedge clk);
        chk("in_ready_idle", 72'(in_ready), 72'd1);
        in_valid     = 1'b1;
        in_data      = d;
        in_msb_first = msb;
        in_thresh    = thr;
        expQ.push_back(model(d, msb, thr));
        @(posedge clk);
        #1;
        acceptCycle  = cycle;
        in_valid     = 1'b0;
        in_data      = ~d;
        in_msb_first = ~msb;
        in_thresh    = ~thr;
    endtask

    task automatic checkOutput(input int holdCycles);
        int waited;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        cur = expQ.pop_front();
        if (!out_valid) begin
            chk("out_valid_timeout", 72'(out_valid), 72'd1);
            return;
        end
        chk("latency", 72'(cycle - acceptCycle), 72'(cur.lat));
        chk("found", 72'(out_found), 72'(cur.found));
        chk("index", 72'(out_index), 72'(cur.index));
        chk("onehot", 72'(out_onehot), 72'(cur.onehot));
        chk("bucket", 72'(out_bucket), 72'(cur.bucket));
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk("hold_valid", 72'(out_valid), 72'd1);
            chk("hold_in_ready", 72'(in_ready), 72'd0);
            chk("hold_index", 72'(out_index), 72'(cur.index));
            chk("hold_bucket", 72'(out_bucket), 72'(cur.bucket));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_cleared", 72'(out_valid), 72'd0);
        chk("in_ready_after", 72'(in_ready), 72'd1);
    endtask

    initial begin
        int seenValid;
        checkCount   = 0;
        failCount    = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_msb_first = 1'b0;
        in_thresh    = '0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 72'(in_ready), 72'd0);
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_outputs", {out_found, out_onehot, out_index, out_bucket}, 72'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] empty word, no hit");
        applyStimulus(72'h0, 1'b1, 4'd0);
        checkOutput(0);

        $display("[TB] top bucket hit, MSB-first");
        applyStimulus(72'h1 << 68, 1'b1, 4'd0);
        checkOutput(0);

        $display("[TB] two-bucket word, both directions and thresholds");
        applyStimulus(72'h500300, 1'b1, 4'd0);
        checkOutput(0);
        applyStimulus(72'h500300, 1'b0, 4'd0);
        checkOutput(0);
        applyStimulus(72'h500300, 1'b1, 4'd4);
        checkOutput(0);
        applyStimulus(72'h500300, 1'b1, 4'd5);
        checkOutput(0);
        applyStimulus(72'h500300, 1'b0, 4'd3);
        checkOutput(0);
        applyStimulus(72'hFFFF_FFFF_FFFF_FFFF_FF, 1'b0, 4'hF);
        checkOutput(0);
        applyStimulus(72'h0123_4567_89AB_CDEF_01, 1'b0, 4'd7);
        checkOutput(0);

        $display("[TB] back-pressure hold");
        applyStimulus(72'h500300, 1'b0, 4'd0);
        checkOutput(10);

        $display("[TB] reset during scan");
        applyStimulus(72'h500300, 1'b1, 4'd0);
        void'(expQ.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 72'(in_ready), 72'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready_after", 72'(in_ready), 72'd1);
        chk("midrst_outputs", {out_found, out_onehot, out_index, out_bucket}, 72'd0);
        seenValid = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seenValid = 1;
        end
        chk("midrst_no_valid", 72'(seenValid), 72'd0);
        applyStimulus(72'h1 << 68, 1'b1, 4'd0);
        checkOutput(0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
